// File: rtl/trail_collision_map_if.sv
// Plot stream, collision query and clear control between the game loop (master)
// and the trail collision map (slave).
interface trail_collision_map_if;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot;
    logic [7:0] q_x;
    logic [6:0] q_y;
    logic       q_req;
    logic       q_ack;
    logic       q_hit;
    logic [1:0] q_owner;
    logic       clear_req;
    logic       busy;

    modport master (
        output plot_x, plot_y, plot_colour, plot,
        output q_x, q_y, q_req, clear_req,
        input  q_ack, q_hit, q_owner, busy
    );

    modport slave (
        input  plot_x, plot_y, plot_colour, plot,
        input  q_x, q_y, q_req, clear_req,
        output q_ack, q_hit, q_owner, busy
    );
endinterface

// File: rtl/trail_collision_map.sv
// Shadow owner map of the playfield, fed by the VGA plot stream, answering pipelined collision queries.
// Build macro TRAIL_MAP_BORDER_WALL_EN: the clear sweep paints the arena border as owner 3.
module trail_collision_map #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned DEPTH  = WIDTH * HEIGHT
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    trail_collision_map_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_addr;
    logic          w_clr_last;
    logic [1:0]    w_clr_data;

    logic [1:0]    r_mem [DEPTH];
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [1:0]    w_wdata;
    logic [1:0]    r_rd_data;

    logic          w_run_ok;
    logic          w_plot_in;
    logic          w_q_in;
    logic          w_q_take;
    logic [1:0]    w_plot_owner;
    logic          r_s1_v;
    logic          r_s1_oob;
    logic          r_s2_v;
    logic [1:0]    r_s2_owner;

    function automatic logic [AW-1:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
        logic [AW-1:0] ya;
        logic [AW-1:0] xa;
        ya = AW'(y);
        xa = AW'(x);
        if (WIDTH == 160)
            cell_addr = (ya << 7) + (ya << 5) + xa;
        else
            cell_addr = AW'(32'(y) * WIDTH + 32'(x));
    endfunction

    assign w_clr_last = (r_clr_addr == AW'(DEPTH - 1));
    assign w_run_ok   = (r_state == S_RUN) && !bus.clear_req;
    assign w_plot_in  = (32'(bus.plot_x) < WIDTH) && (32'(bus.plot_y) < HEIGHT);
    assign w_q_in     = (32'(bus.q_x) < WIDTH) && (32'(bus.q_y) < HEIGHT);
    assign w_q_take   = w_run_ok && bus.q_req;
    assign bus.busy   = (r_state == S_CLEAR);

    always_comb begin
        w_plot_owner = 2'd3;
        case (bus.plot_colour)
            3'b000:  w_plot_owner = 2'd0;
            3'b001:  w_plot_owner = 2'd1;
            3'b100:  w_plot_owner = 2'd2;
            default: w_plot_owner = 2'd3;
        endcase
    end

`ifdef TRAIL_MAP_BORDER_WALL_EN
    logic [7:0] r_clr_x;
    logic [6:0] r_clr_y;

    // Column/row shadow of the sweep address, so the border test needs no divider.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_clr_x <= '0;
            r_clr_y <= '0;
        end else if (r_state == S_CLEAR) begin
            if (w_clr_last) begin
                r_clr_x <= '0;
                r_clr_y <= '0;
            end else if (32'(r_clr_x) == WIDTH - 1) begin
                r_clr_x <= '0;
                r_clr_y <= r_clr_y + 1'b1;
            end else begin
                r_clr_x <= r_clr_x + 1'b1;
            end
        end
    end

    assign w_clr_data = (r_clr_x == 8'd10 || r_clr_x == 8'd149 ||
                         r_clr_y == 7'd17 || r_clr_y == 7'd108) ? 2'd3 : 2'd0;
`else
    assign w_clr_data = '0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_clr_addr;
        w_wdata     = w_clr_data;
        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
                if (w_clr_last)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.clear_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (bus.plot && w_plot_in) begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(bus.plot_x, bus.plot_y);
                    w_wdata = w_plot_owner;
                end
            end
        endcase
    end

    // Read is launched from the unregistered query address so a same-edge plot is not yet visible.
    always_ff @(posedge CLOCK_50) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (w_q_take && w_q_in)
            r_rd_data <= r_mem[cell_addr(bus.q_x, bus.q_y)];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_s1_v      <= 1'b0;
            r_s1_oob    <= 1'b0;
            r_s2_v      <= 1'b0;
            r_s2_owner  <= '0;
            bus.q_ack   <= 1'b0;
            bus.q_hit   <= 1'b0;
            bus.q_owner <= '0;
        end else begin
            r_s1_v     <= w_q_take;
            r_s1_oob   <= !w_q_in;
            r_s2_v     <= r_s1_v && w_run_ok;
            r_s2_owner <= r_s1_oob ? 2'd3 : r_rd_data;
            bus.q_ack  <= r_s2_v && w_run_ok;
            if (r_s2_v && w_run_ok) begin
                bus.q_hit   <= (r_s2_owner != 2'd0);
                bus.q_owner <= r_s2_owner;
            end
        end
    end
endmodule

// File: tb/tb_trail_collision_map.sv
// Bench for trail_collision_map: owner-map model checked every cycle plus directed literal expectations.
// Honours TRAIL_MAP_BORDER_WALL_EN when building the expected cleared map.
module tb_trail_collision_map;
    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    trail_collision_map_if bus ();

    trail_collision_map #(.WIDTH(160), .HEIGHT(120)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    localparam int SWEEP = 160 * 120;

    int checks   = 0;
    int failures = 0;

    typedef struct { int due; int owner; } pend_t;
    typedef struct { int hit; int owner; } ack_t;

    int    owner_map [160][120];
    pend_t pend [$];
    ack_t  seen [$];
    int    cyc        = 0;
    int    clear_left = 0;
    bit    armed      = 1'b0;
    bit    exp_ack    = 1'b0;
    int    exp_hit    = 0;
    int    exp_owner  = 0;
    int    rd         = 0;

    function automatic int colour_owner(input logic [2:0] c);
        if (c == 3'b001) return 1;
        if (c == 3'b100) return 2;
        if (c == 3'b000) return 0;
        return 3;
    endfunction

    function automatic int init_owner(input int x, input int y);
`ifdef TRAIL_MAP_BORDER_WALL_EN
        if (x == 10 || x == 149 || y == 17 || y == 108) return 3;
`endif
        return 0 * (x + y);
    endfunction

    function automatic void reset_map();
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                owner_map[x][y] = init_owner(x, y);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: a sweep is an atomic map reset followed by SWEEP dead cycles; queries read the map before the plot lands.
    always @(posedge CLOCK_50) begin
        cyc++;
        exp_ack = 1'b0;
        if (!resetn) begin
            armed      = 1'b1;
            clear_left = SWEEP;
            pend.delete();
            exp_hit    = 0;
            exp_owner  = 0;
            reset_map();
        end else if (armed) begin
            if (clear_left > 0) begin
                clear_left--;
            end else if (bus.clear_req) begin
                clear_left = SWEEP;
                pend.delete();
                reset_map();
            end else begin
                if (bus.q_req) begin
                    pend_t p;
                    p.due = cyc + 2;
                    if (int'(bus.q_x) >= 160 || int'(bus.q_y) >= 120)
                        p.owner = 3;
                    else
                        p.owner = owner_map[bus.q_x][bus.q_y];
                    pend.push_back(p);
                end
                if (bus.plot && int'(bus.plot_x) < 160 && int'(bus.plot_y) < 120)
                    owner_map[bus.plot_x][bus.plot_y] = colour_owner(bus.plot_colour);
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_ack   = 1'b1;
                exp_owner = pend[0].owner;
                exp_hit   = (exp_owner != 0) ? 1 : 0;
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (armed) begin
            chk("busy",    int'(bus.busy),    (clear_left > 0) ? 1 : 0);
            chk("q_ack",   int'(bus.q_ack),   int'(exp_ack));
            chk("q_hit",   int'(bus.q_hit),   exp_hit);
            chk("q_owner", int'(bus.q_owner), exp_owner);
            if (bus.q_ack)
                seen.push_back('{int'(bus.q_hit), int'(bus.q_owner)});
        end
    end

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic take_ack(input string name, input int hit, input int owner);
        if (seen.size() <= rd) begin
            checks++;
            failures++;
            $display("FAIL %s: actual=no_ack required=ack", name);
        end else begin
            chk({name, "_hit"},   seen[rd].hit,   hit);
            chk({name, "_owner"}, seen[rd].owner, owner);
            rd++;
        end
    endtask

    task automatic drive_query(input int x, input int y);
        bus.q_x   = 8'(x);
        bus.q_y   = 7'(y);
        bus.q_req = 1'b1;
    endtask

    task automatic query_chk(input string name, input int x, input int y, input int hit, input int owner);
        drive_query(x, y);
        step();
        bus.q_req = 1'b0;
        step();
        step();
        take_ack(name, hit, owner);
    endtask

    task automatic plot_px(input int x, input int y, input logic [2:0] c);
        bus.plot_x      = 8'(x);
        bus.plot_y      = 7'(y);
        bus.plot_colour = c;
        bus.plot        = 1'b1;
        step();
        bus.plot = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy && n < 25000);
    endtask

    int n;
    int border_owner;

    initial begin
        bus.plot_x = '0; bus.plot_y = '0; bus.plot_colour = '0; bus.plot = 1'b0;
        bus.q_x = '0; bus.q_y = '0; bus.q_req = 1'b0; bus.clear_req = 1'b0;
`ifdef TRAIL_MAP_BORDER_WALL_EN
        border_owner = 3;
`else
        border_owner = 0;
`endif

        resetn = 1'b0;
        drive_query(25, 100);
        step(); step(); step();
        bus.q_req = 1'b0;
        chk("rst_busy",    int'(bus.busy),    1);
        chk("rst_q_ack",   int'(bus.q_ack),   0);
        chk("rst_q_hit",   int'(bus.q_hit),   0);
        chk("rst_q_owner", int'(bus.q_owner), 0);

        resetn = 1'b1;
        count_busy(n);
        chk("busy_len_reset", n, 19200);

        query_chk("empty_25_100", 25, 100, 0, 0);
        plot_px(25, 100, 3'b001);
        query_chk("p1_25_100", 25, 100, 1, 1);
        plot_px(135, 100, 3'b100);
        query_chk("p2_135_100", 135, 100, 1, 2);

        // Same-edge plot and query, then the same query one cycle later.
        bus.plot_x = 8'd40; bus.plot_y = 7'd50; bus.plot_colour = 3'b100; bus.plot = 1'b1;
        drive_query(40, 50);
        step();
        bus.plot = 1'b0;
        step();
        bus.q_req = 1'b0;
        step();
        take_ack("rbw_old", 0, 0);
        step();
        take_ack("rbw_new", 1, 2);

        query_chk("oob_x160", 160, 0, 1, 3);
        query_chk("oob_y120", 0, 120, 1, 3);
        plot_px(200, 5, 3'b001);
        query_chk("no_alias_40_5", 40, 5, 0, 0);

        plot_px(1, 1, 3'b010);
        drive_query(25, 100);  step();
        drive_query(135, 100); step();
        drive_query(1, 1);     step();
        bus.q_req = 1'b0;
        step(); step();
        take_ack("b2b_0", 1, 1);
        take_ack("b2b_1", 1, 2);
        take_ack("b2b_2", 1, 3);

        plot_px(30, 30, 3'b001);
        plot_px(30, 30, 3'b000);
        query_chk("erase_30_30", 30, 30, 0, 0);

        // Clear with a query in flight; pokes during the sweep must be ignored.
        drive_query(135, 100);
        step();
        bus.q_req = 1'b0;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        n = 0;
        do begin
            bus.clear_req = (n == 100);
            bus.plot      = (n == 200);
            bus.plot_x = 8'd25; bus.plot_y = 7'd100; bus.plot_colour = 3'b001;
            bus.q_req     = (n == 300);
            step();
            n++;
        end while (bus.busy && n < 25000);
        bus.clear_req = 1'b0; bus.plot = 1'b0; bus.q_req = 1'b0;
        chk("busy_len_clear", n, 19200);
        chk("no_ack_dropped", seen.size(), rd);

        query_chk("cleared_25_100", 25, 100, 0, 0);
        query_chk("border_10_50", 10, 50, (border_owner != 0) ? 1 : 0, border_owner);
        query_chk("inner_11_50", 11, 50, 0, 0);

        // Reset part-way through a sweep restarts it from the beginning.
        plot_px(60, 60, 3'b100);
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 1000; i++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        count_busy(n);
        chk("busy_len_midreset", n, 19200);
        query_chk("after_reset_60_60", 60, 60, 0, 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
